// File: rtl/clock_period_meter.sv
// Measures the period and high time of an asynchronous clock-like input in
// inclk cycles, with a stale-input timeout and a running measurement count.
`timescale 1ns/1ps
module clock_period_meter #(
  parameter int unsigned TIMEOUT = 50_000_000
) (
  input  logic        inclk,
  input  logic        reset_n,
  input  logic        sig_in,
  output logic [31:0] period,
  output logic [31:0] high_time,
  output logic        valid,
  output logic        timeout,
  output logic [15:0] meas_count
);

  typedef enum logic [1:0] {ARM, MEASURE, STALE} state_t;

  localparam logic [31:0] TIMEOUT_CNT = 32'(TIMEOUT);
  localparam logic [31:0] CNT_MAX     = '1;

  logic       sync_meta;
  logic       sync;
  logic       prev;
  logic [1:0] fill;
  logic       seen_low;
  logic       rise;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] hcnt;

  // fill marks when sync carries a genuinely sampled value rather than its
  // reset zero, so an input held high through reset is never taken as a rise.
  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      prev      <= 1'b0;
      fill      <= 2'b00;
      seen_low  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value,
      // which is what makes this a shift chain rather than a single wire.
      sync_meta <= sig_in;
      sync      <= sync_meta;
      prev      <= sync;
      fill      <= {fill[0], 1'b1};
      if (fill[1] && !sync) seen_low <= 1'b1;
    end
  end

  assign rise = sync & ~prev & seen_low;

  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARM;
      cnt        <= '0;
      hcnt       <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_count <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      valid <= 1'b0;

      if (rise)                cnt <= 32'd1;
      else if (cnt != CNT_MAX) cnt <= cnt + 32'd1;

      if (rise)                          hcnt <= 32'd1;
      else if (sync && hcnt != CNT_MAX)  hcnt <= hcnt + 32'd1;

      // A rise only produces a result when a measurement was already running;
      // a rise coinciding with the timeout count wins over going stale.
      case (state)
        ARM: begin
          if (rise) state <= MEASURE;
        end
        MEASURE: begin
          if (rise) begin
            period     <= cnt;
            high_time  <= hcnt;
            meas_count <= meas_count + 16'd1;
            valid      <= 1'b1;
          end else if (cnt == TIMEOUT_CNT) begin
            state   <= STALE;
            timeout <= 1'b1;
          end
        end
        STALE: begin
          if (rise) begin
            state   <= MEASURE;
            timeout <= 1'b0;
          end
        end
        default: state <= ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: two instances (short and long timeout) share
// one randomized input and are compared every cycle against an event-level model.
`timescale 1ns/1ps
module tb_clock_period_meter;

  localparam int TO_A = 100;
  localparam int TO_B = 10;

  logic        inclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sig_in = 1'b0;

  logic [31:0] period_a, high_a, period_b, high_b;
  logic        valid_a, timeout_a, valid_b, timeout_b;
  logic [15:0] count_a, count_b;

  clock_period_meter #(.TIMEOUT(TO_A)) dut_a (
    .inclk(inclk), .reset_n(reset_n), .sig_in(sig_in),
    .period(period_a), .high_time(high_a), .valid(valid_a),
    .timeout(timeout_a), .meas_count(count_a)
  );

  clock_period_meter #(.TIMEOUT(TO_B)) dut_b (
    .inclk(inclk), .reset_n(reset_n), .sig_in(sig_in),
    .period(period_b), .high_time(high_b), .valid(valid_b),
    .timeout(timeout_b), .meas_count(count_b)
  );

  always #10 inclk = ~inclk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_RUN, M_LOST} mmode_t;

  typedef struct {
    mmode_t      mode;
    int          last_act;
    logic [31:0] period;
    logic [31:0] high;
    logic [15:0] count;
    logic        valid;
    logic        timeout;
  } model_t;

  typedef struct {
    int t;
    int per;
    int hi;
  } ev_t;

  model_t ma, mb;
  ev_t    evq[$];
  int     k = 0;          // posedge index since reset release
  logic   last_s = 1'b0;
  int     last_rise = -1; // sample index of the previous low-to-high transition
  int     ones = 0;       // high samples since that transition

  function automatic model_t model_clear();
    model_t m;
    m.mode = M_IDLE; m.last_act = 0; m.period = '0; m.high = '0;
    m.count = '0; m.valid = 1'b0; m.timeout = 1'b0;
    return m;
  endfunction

  task automatic model_reset();
    ma = model_clear();
    mb = model_clear();
    evq.delete();
    k = 0; last_s = 1'b0; last_rise = -1; ones = 0;
  endtask

  task automatic model_apply(inout model_t m, input int to_cycles, input bit hit,
                             input int per, input int hi);
    m.valid = 1'b0;
    if (hit) begin
      if (m.mode == M_RUN) begin
        m.period = 32'(per);
        m.high   = 32'(hi);
        m.count  = m.count + 16'd1;
        m.valid  = 1'b1;
      end
      m.mode = M_RUN; m.last_act = k; m.timeout = 1'b0;
    end else if (m.mode == M_RUN && (k - m.last_act) == to_cycles) begin
      m.mode = M_LOST; m.timeout = 1'b1;
    end
  endtask

  // A low-to-high transition between consecutive post-reset samples becomes
  // visible at the outputs two clocks after the sample that shows it high.
  task automatic model_step(input logic s);
    ev_t e;
    bit  hit;
    int  per, hi;
    k++;
    if (k >= 2 && !last_s && s) begin
      e.t = k + 2; e.per = k - last_rise; e.hi = ones;
      evq.push_back(e);
      last_rise = k; ones = 0;
    end
    if (s) ones++;
    last_s = s;
    hit = 1'b0; per = 0; hi = 0;
    if (evq.size() > 0 && evq[0].t == k) begin
      hit = 1'b1; per = evq[0].per; hi = evq[0].hi;
      void'(evq.pop_front());
    end
    model_apply(ma, TO_A, hit, per, hi);
    model_apply(mb, TO_B, hit, per, hi);
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    model_reset();
    forever begin
      @(posedge inclk);
      if (!reset_n) begin
        model_reset();
      end else begin
        model_step(sig_in);
        #1;
        check("a.period",  period_a,       ma.period);
        check("a.high",    high_a,         ma.high);
        check("a.count",   32'(count_a),   32'(ma.count));
        check("a.valid",   32'(valid_a),   32'(ma.valid));
        check("a.timeout", 32'(timeout_a), 32'(ma.timeout));
        check("b.period",  period_b,       mb.period);
        check("b.high",    high_b,         mb.high);
        check("b.count",   32'(count_b),   32'(mb.count));
        check("b.valid",   32'(valid_b),   32'(mb.valid));
        check("b.timeout", 32'(timeout_b), 32'(mb.timeout));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_wave(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      repeat (hi) @(negedge inclk);
      sig_in = 1'b0;
      repeat (per - hi) @(negedge inclk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".a.period"},  period_a, 32'd0);
    check({tag, ".a.high"},    high_a, 32'd0);
    check({tag, ".a.count"},   32'(count_a), 32'd0);
    check({tag, ".a.valid"},   32'(valid_a), 32'd0);
    check({tag, ".a.timeout"}, 32'(timeout_a), 32'd0);
    check({tag, ".b.period"},  period_b, 32'd0);
    check({tag, ".b.count"},   32'(count_b), 32'd0);
    check({tag, ".b.timeout"}, 32'(timeout_b), 32'd0);
  endtask

  initial begin
    int c0;
    int per, hi;
    reset_n = 1'b0;
    sig_in  = 1'b0;
    repeat (3) @(negedge inclk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge inclk);

    // divide-by-10: six rises from ARM give five results; short timeout equals period
    run_wave(10, 5, 6);
    check("div10.period", period_a, 32'd10);
    check("div10.high",   high_a, 32'd5);
    check("div10.count",  32'(count_a), 32'd5);
    check("div10.b.count",   32'(count_b), 32'd5);
    check("div10.b.timeout", 32'(timeout_b), 32'd0);

    run_wave(7, 4, 5);
    check("p7.period", period_a, 32'd7);
    check("p7.high",   high_a, 32'd4);
    run_wave(12, 6, 3);
    check("p12.period", period_a, 32'd12);
    check("p12.high",   high_a, 32'd6);

    // input stops low, then restarts
    run_wave(10, 5, 3);
    repeat (120) @(negedge inclk);
    check("stale.timeout", 32'(timeout_a), 32'd1);
    check("stale.period",  period_a, 32'd10);
    c0 = int'(count_a);
    run_wave(10, 5, 1);
    check("restart.timeout", 32'(timeout_a), 32'd0);
    check("restart.count",   32'(count_a), 32'(c0));
    run_wave(10, 5, 1);
    check("restart2.count",  32'(count_a), 32'(c0 + 1));

    // input high through reset
    sig_in = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge inclk);
    reset_n = 1'b1;
    repeat (20) @(negedge inclk);
    check("hi_reset.count", 32'(count_a), 32'd0);
    sig_in = 1'b0;
    repeat (5) @(negedge inclk);
    run_wave(8, 4, 2);
    check("hi_reset.count2", 32'(count_a), 32'd1);
    check("hi_reset.period", period_a, 32'd8);

    // reset mid-period
    run_wave(9, 3, 3);
    sig_in = 1'b1;
    repeat (4) @(negedge inclk);
    #3 reset_n = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (2) @(negedge inclk);
    reset_n = 1'b1;

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          per = int'($urandom_range(2, 30));
          hi  = int'($urandom_range(1, per - 1));
          run_wave(per, hi, int'($urandom_range(1, 4)));
        end
        2: begin
          for (int c = 0; c < 20; c++) begin
            sig_in = 1'($urandom_range(0, 1));
            @(negedge inclk);
          end
        end
        default: begin
          sig_in = 1'b0;
          repeat ($urandom_range(5, 130)) @(negedge inclk);
        end
      endcase
    end

    sig_in = 1'b0;
    repeat (5) @(negedge inclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
